ahb_stream_loader: RTL

AHB-Lite bus master that sits directly upstream of the on-chip AHB-Lite memory. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. It writes those words as single NONSEQ word transfers to consecutive addresses starting at BASE_ADDR. It is used to load program images into memory before the CPU leaves reset, and to load them at runtime.

---
 rtl/ahb_lite_pkg.sv | 23 ++
 rtl/byte_packer.sv | 68 ++++++
 rtl/ahb_stream_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg
// Shared AHB-Lite encodings and the loader FSM state type.
//   HTRANS_IDLE / HTRANS_NONSEQ : transfer type encodings used by the loader
//   HSIZE_WORD, HBURST_SINGLE   : fixed transfer shape (single 32-bit word)
//   HPROT_DATA                  : privileged data access
//   loader_state_e              : ahb_stream_loader FSM states
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StAddr,
        StData,
        StErr
    } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// byte_packer
// Packs accepted bytes little-endian into a 32-bit word (lane 0 = bits 7:0).
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_byte         : byte to place in the current lane
//   i_accept       : i_byte is accepted this cycle
//   i_last         : accepted byte is the final byte of the image
//   i_clear        : restart at lane 0 with an empty pack register
//   o_word         : completed word including the byte being accepted, unfilled lanes zero
//   o_word_valid   : o_word is complete this cycle (lane 3 or last byte accepted)
module byte_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_byte,
    input  logic        i_accept,
    input  logic        i_last,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_lane;
    logic [31:0] r_pack;
    logic [31:0] w_merged;
    logic [31:0] w_fill_mask;

    // Word is presented combinationally so the owner can capture it on the
    // same edge that accepts its final byte.
    always_comb begin
        w_merged = r_pack;
        unique case (r_lane)
            2'd0: w_merged[7:0]   = i_byte;
            2'd1: w_merged[15:8]  = i_byte;
            2'd2: w_merged[23:16] = i_byte;
            2'd3: w_merged[31:24] = i_byte;
            default: w_merged = r_pack;
        endcase
    end

    // Lanes above the one being written belong to no byte of a short final word.
    always_comb begin
        w_fill_mask = 32'hFFFF_FFFF;
        unique case (r_lane)
            2'd0: w_fill_mask = 32'h0000_00FF;
            2'd1: w_fill_mask = 32'h0000_FFFF;
            2'd2: w_fill_mask = 32'h00FF_FFFF;
            2'd3: w_fill_mask = 32'hFFFF_FFFF;
            default: w_fill_mask = 32'hFFFF_FFFF;
        endcase
    end

    assign o_word       = w_merged & w_fill_mask;
    assign o_word_valid = i_accept && (i_last || (r_lane == 2'd3));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lane <= 2'd0;
            r_pack <= '0;
        end else if (i_clear || o_word_valid) begin
            r_lane <= 2'd0;
            r_pack <= '0;
        end else if (i_accept) begin
            r_lane <= r_lane + 2'd1;
            r_pack <= w_merged;
        end
    end

endmodule

// File: rtl/ahb_stream_loader.sv
// ahb_stream_loader
// AHB-Lite write master: packs a byte stream into words and writes them as
// single NONSEQ word transfers to consecutive addresses from BASE_ADDR.
// Ports:
//   HCLK, HRESETn          : clock, synchronous active-low reset
//   start                  : pulse to begin a load (ignored while busy)
//   s_data/s_valid/s_last  : byte stream in; s_ready out
//   HADDR..HWDATA          : AHB-Lite master outputs (all registered)
//   HREADY, HRESP          : selected slave response
//   busy, done, error      : status (done is a one-cycle pulse, error is sticky)
//   word_count             : words completed in the current or last load
module ahb_stream_loader
    import ahb_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 8192
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    loader_state_e r_state, w_state_d;

    logic [31:0] r_addr, w_addr_d;
    logic        r_last_word, w_last_word_d;
    logic [31:0] r_haddr, w_haddr_d;
    logic [1:0]  r_htrans, w_htrans_d;
    logic        r_hwrite, w_hwrite_d;
    logic [31:0] r_hwdata, w_hwdata_d;
    logic        r_s_ready, w_s_ready_d;
    logic        r_busy, w_busy_d;
    logic        r_done, w_done_d;
    logic        r_error, w_error_d;
    logic [15:0] r_word_count, w_word_count_d;

    logic        w_accept;
    logic        w_clear;
    logic [31:0] w_word;
    logic        w_word_valid;
    logic [15:0] w_count_inc;

    assign w_accept    = (r_state == StCollect) && s_valid;
    assign w_count_inc = r_word_count + 16'd1;

    byte_packer u_packer (
        .i_clk        (HCLK),
        .i_rst_n      (HRESETn),
        .i_byte       (s_data),
        .i_accept     (w_accept),
        .i_last       (s_last),
        .i_clear      (w_clear),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_state_d      = r_state;
        w_addr_d       = r_addr;
        w_last_word_d  = r_last_word;
        w_haddr_d      = r_haddr;
        w_htrans_d     = HTRANS_IDLE;
        w_hwrite_d     = 1'b0;
        w_hwdata_d     = r_hwdata;
        w_busy_d       = r_busy;
        w_done_d       = 1'b0;
        w_error_d      = r_error;
        w_word_count_d = r_word_count;
        w_clear        = 1'b0;

        unique case (r_state)
            StIdle, StErr: begin
                if (start) begin
                    w_state_d      = StCollect;
                    w_addr_d       = BASE_ADDR;
                    w_word_count_d = '0;
                    w_error_d      = 1'b0;
                    w_busy_d       = 1'b1;
                    w_clear        = 1'b1;
                end
            end
            StCollect: begin
                if (w_word_valid) begin
                    w_state_d     = StAddr;
                    w_haddr_d     = r_addr;
                    w_htrans_d    = HTRANS_NONSEQ;
                    w_hwrite_d    = 1'b1;
                    w_hwdata_d    = w_word;
                    w_last_word_d = s_last;
                end
            end
            StAddr: begin
                // Address phase is held until the slave takes it.
                w_htrans_d = HTRANS_NONSEQ;
                w_hwrite_d = 1'b1;
                if (HREADY) begin
                    w_state_d  = StData;
                    w_htrans_d = HTRANS_IDLE;
                    w_hwrite_d = 1'b0;
                end
            end
            StData: begin
                // An error response aborts at its first cycle; the second
                // (HREADY=1) cycle finds the loader already idle on the bus.
                if (HRESP) begin
                    w_state_d = StErr;
                    w_error_d = 1'b1;
                    w_busy_d  = 1'b0;
                end else if (HREADY) begin
                    w_word_count_d = w_count_inc;
                    w_addr_d       = r_addr + 32'd4;
                    if (r_last_word) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                        w_busy_d  = 1'b0;
                    end else if ({16'd0, w_count_inc} >= MAX_WORDS) begin
                        w_state_d = StErr;
                        w_error_d = 1'b1;
                        w_busy_d  = 1'b0;
                    end else begin
                        w_state_d = StCollect;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    assign w_s_ready_d = (w_state_d == StCollect);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state      <= StIdle;
            r_addr       <= BASE_ADDR;
            r_last_word  <= 1'b0;
            r_haddr      <= BASE_ADDR;
            r_htrans     <= HTRANS_IDLE;
            r_hwrite     <= 1'b0;
            r_hwdata     <= '0;
            r_s_ready    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_state      <= w_state_d;
            r_addr       <= w_addr_d;
            r_last_word  <= w_last_word_d;
            r_haddr      <= w_haddr_d;
            r_htrans     <= w_htrans_d;
            r_hwrite     <= w_hwrite_d;
            r_hwdata     <= w_hwdata_d;
            r_s_ready    <= w_s_ready_d;
            r_busy       <= w_busy_d;
            r_done       <= w_done_d;
            r_error      <= w_error_d;
            r_word_count <= w_word_count_d;
        end
    end

    assign s_ready    = r_s_ready;
    assign HADDR      = r_haddr;
    assign HTRANS     = r_htrans;
    assign HWRITE     = r_hwrite;
    assign HSIZE      = HSIZE_WORD;
    assign HBURST     = HBURST_SINGLE;
    assign HPROT      = HPROT_DATA;
    assign HWDATA     = r_hwdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_word_count;

endmodule
